// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS-style controller.
// Holds the FSM state encoding, opcode/funct constants, aluop codes
// and ALU control encodings used by mc_control and alu_decoder.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQ     = 4'd8,
        BNE     = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11,
        JUMP    = 4'd12
    } state_t;

    // opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    // aluop encodings
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // alu_control encodings
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_control_alu_decoder.sv
// alu_decoder: combinational aluop/funct -> alu_control translation.
// Ports:
//   aluop       in  2  operation class from the main FSM
//   funct       in  6  R-type function field
//   alu_control out 3  ALU operation select
module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   alu_control = ALU_ADD;
                    F_SUB:   alu_control = ALU_SUB;
                    F_AND:   alu_control = ALU_AND;
                    F_OR:    alu_control = ALU_OR;
                    F_SLT:   alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// mc_control: Moore FSM control unit for a multicycle MIPS subset
// (lw, sw, R-type, beq, bne, addi, j).
// Ports:
//   clk_100M, clk_en, rst     clock, clock enable, sync active-high reset
//   opcode, funct, zero       instruction fields and ALU zero flag
//   iord..alu_control         datapath controls (Moore, from state)
//   pc_en                     PC load strobe (zero-latency on zero)
//   illegal_op                high in DECODE for an undecoded opcode
//   state                     current FSM state for debug
module mc_control
    import mc_pkg::*;
#(
    parameter int BNE_EN = 1
) (
    input  logic       clk_100M,
    input  logic       clk_en,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic       pc_en,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic BNE_OK = (BNE_EN != 0);

    state_t     state_q, state_d, out_state;
    logic [1:0] aluop;
    logic       pc_write, branch, branch_ne, illegal;
    logic       ir_write_s, mem_write_s, reg_write_s;

    always_ff @(posedge clk_100M) begin
        if (rst)
            state_q <= FETCH;
        else if (clk_en)
            state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQ;
                    OP_BNE:       state_d = BNE_OK ? BNE : FETCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            RTYPEEX: state_d = RTYPEWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // While in reset the datapath sees FETCH controls; strobes are masked below.
    assign out_state = rst ? FETCH : state_q;

    always_comb begin
        iord        = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write_s = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        aluop       = ALUOP_ADD;
        pc_write    = 1'b0;
        branch      = 1'b0;
        branch_ne   = 1'b0;
        illegal     = 1'b0;
        case (out_state)
            FETCH: begin
                alu_src_b  = 2'b01;
                ir_write_s = 1'b1;
                pc_write   = 1'b1;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
                    OP_BNE:  illegal = !BNE_OK;
                    default: illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                mem_to_reg  = 1'b1;
                reg_write_s = 1'b1;
            end
            MEMWR: begin
                iord        = 1'b1;
                mem_write_s = 1'b1;
            end
            RTYPEEX: begin
                alu_src_a = 1'b1;
                aluop     = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                reg_dst     = 1'b1;
                reg_write_s = 1'b1;
            end
            BEQ, BNE: begin
                alu_src_a = 1'b1;
                aluop     = ALUOP_SUB;
                pc_src    = 2'b01;
                branch    = (out_state == BEQ);
                branch_ne = (out_state == BNE);
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDIWB: reg_write_s = 1'b1;
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign ir_write   = ir_write_s & ~rst;
    assign mem_write  = mem_write_s & ~rst;
    assign reg_write  = reg_write_s & ~rst;
    assign illegal_op = illegal & ~rst;
    assign pc_en      = ~rst & (pc_write | (branch & zero) | (branch_ne & ~zero));
    assign state      = state_q;

    alu_decoder u_alu_dec (
        .aluop       (aluop),
        .funct       (funct),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;
    logic       clk_100M = 1'b0;
    logic       clk_en, rst, zero;
    logic [5:0] opcode, funct;

    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic       pc_en, illegal_op;
    logic [3:0] state;

    logic       b_iord, b_mem_write, b_ir_write, b_reg_dst, b_mem_to_reg, b_reg_write, b_alu_src_a;
    logic [1:0] b_alu_src_b, b_pc_src;
    logic [2:0] b_alu_control;
    logic       b_pc_en, b_illegal_op;
    logic [3:0] b_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_100M = ~clk_100M;

    mc_control u_dut (
        .clk_100M(clk_100M), .clk_en(clk_en), .rst(rst),
        .opcode(opcode), .funct(funct), .zero(zero),
        .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .alu_control(alu_control), .pc_en(pc_en), .illegal_op(illegal_op),
        .state(state)
    );

    mc_control #(.BNE_EN(0)) u_nobne (
        .clk_100M(clk_100M), .clk_en(clk_en), .rst(rst),
        .opcode(opcode), .funct(funct), .zero(zero),
        .iord(b_iord), .mem_write(b_mem_write), .ir_write(b_ir_write),
        .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write),
        .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .pc_src(b_pc_src),
        .alu_control(b_alu_control), .pc_en(b_pc_en), .illegal_op(b_illegal_op),
        .state(b_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock and settle past the edge
    task automatic tick();
        @(posedge clk_100M);
        #1;
    endtask

    initial begin
        int mw_cnt;
        logic [3:0] exp_st [1:8];
        exp_st = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd5, 4'd5, 4'd0};

        rst = 1'b1; clk_en = 1'b1; zero = 1'b0; opcode = 6'b0; funct = 6'b0;
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_ir_write", ir_write, 0);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_alu_src_b", alu_src_b, 2'b01);
        rst = 1'b0; #1;
        chk("fetch_ir_write", ir_write, 1);
        chk("fetch_pc_en", pc_en, 1);
        chk("fetch_alu_ctl", alu_control, 3'b010);

        // lw
        opcode = 6'b100011;
        tick(); chk("lw_decode", state, 1); chk("lw_dec_srcb", alu_src_b, 2'b11);
        chk("lw_dec_pc_en", pc_en, 0);
        tick(); chk("lw_memadr", state, 2); chk("lw_adr_srca", alu_src_a, 1);
        chk("lw_adr_srcb", alu_src_b, 2'b10);
        tick(); chk("lw_memrd", state, 3); chk("lw_rd_iord", iord, 1);
        chk("lw_rd_regwr", reg_write, 0);
        tick(); chk("lw_memwb", state, 4); chk("lw_wb_regwr", reg_write, 1);
        chk("lw_wb_m2r", mem_to_reg, 1); chk("lw_wb_iord", iord, 0);
        tick(); chk("lw_fetch", state, 0); chk("lw_fetch_regwr", reg_write, 0);

        // R-type funct table
        opcode = 6'b000000;
        funct = 6'b100010;
        tick(); tick(); chk("r_sub_state", state, 6); chk("r_sub_ctl", alu_control, 3'b110);
        tick(); chk("r_wb_regdst", reg_dst, 1); chk("r_wb_regwr", reg_write, 1);
        tick();
        funct = 6'b101010;
        tick(); tick(); chk("r_slt_ctl", alu_control, 3'b111);
        tick(); tick();
        funct = 6'b111111;
        tick(); tick(); chk("r_dflt_ctl", alu_control, 3'b010);
        tick(); tick(); chk("r_back_fetch", state, 0);

        // beq
        opcode = 6'b000100; zero = 1'b1;
        tick(); tick(); chk("beq_state", state, 8); chk("beq_z1_pc_en", pc_en, 1);
        chk("beq_pc_src", pc_src, 2'b01); chk("beq_alu_ctl", alu_control, 3'b110);
        zero = 1'b0; #1; chk("beq_z0_pc_en", pc_en, 0);
        tick(); chk("beq_fetch", state, 0);

        // jump
        opcode = 6'b000010;
        tick(); tick(); chk("j_state", state, 12); chk("j_pc_src", pc_src, 2'b10);
        chk("j_pc_en", pc_en, 1);
        tick();

        // illegal opcode
        opcode = 6'b111111;
        tick(); chk("ill_state", state, 1); chk("ill_pulse", illegal_op, 1);
        chk("ill_regwr", reg_write, 0); chk("ill_memwr", mem_write, 0); chk("ill_pc_en", pc_en, 0);
        tick(); chk("ill_fetch", state, 0); chk("ill_pulse_end", illegal_op, 0);

        // sw with clk_en toggling every clock
        opcode = 6'b101011; mw_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            clk_en = (i % 2 == 0);
            tick();
            chk($sformatf("sw_en_st%0d", i), state, exp_st[i]);
            if (mem_write) mw_cnt++;
        end
        chk("sw_en_mw_cnt", mw_cnt, 2);
        clk_en = 1'b1;

        // bne on both builds (desynchronises them until the reset below)
        opcode = 6'b000101; zero = 1'b0;
        tick(); chk("bne_nobne_ill", b_illegal_op, 1); chk("bne_dflt_ill", illegal_op, 0);
        tick(); chk("bne_state", state, 9); chk("bne_z0_pc_en", pc_en, 1);
        chk("bne_nobne_fetch", b_state, 0);
        zero = 1'b1; #1; chk("bne_z1_pc_en", pc_en, 0);
        tick();

        // reset during MEMWR
        opcode = 6'b101011;
        tick(); tick(); tick(); chk("rstmid_memwr", state, 5); chk("rstmid_mw_pre", mem_write, 1);
        rst = 1'b1; #1;
        chk("rstmid_mw_now", mem_write, 0); chk("rstmid_iord", iord, 0);
        tick(); chk("rstmid_state", state, 0); chk("rstmid_nobne_st", b_state, 0);
        chk("rstmid_ir_wr", ir_write, 0);
        rst = 1'b0; #1;
        chk("rstmid_fetch_irw", ir_write, 1); chk("rstmid_fetch_pc_en", pc_en, 1);
        tick(); chk("rstmid_decode", state, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter BNE_EN, default 1, meaning 1 = decode bne (000101), 0 = treat bne as illegal.
REQ-002 SHALL have port clk_100M  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port clk_en  input  1  clock enable; state advances only on edges where clk_en=1.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports opcode  input  6  and funct  input  6, both taken from the instruction register.
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have 1-bit output ports iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a; 2-bit output ports alu_src_b, pc_src; and a 3-bit output port alu_control.
REQ-008 SHALL have port pc_en  output  1  PC load strobe.
REQ-009 SHALL have port illegal_op  output  1  pulse on an undecoded opcode.
REQ-010 SHALL have port state  output  4  current FSM state, for debug.

Function
REQ-011 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQ, BNE, ADDIEX, ADDIWB, JUMP.
REQ-012 SHALL use these transitions, each taken on a clk_en edge:
- FETCH->DECODE.
- DECODE: lw/sw->MEMADR; R(000000)->RTYPEEX; beq(000100)->BEQ; bne->BNE; addi(001000)->ADDIEX; j(000010)->JUMP; any other opcode->FETCH.
- MEMADR: lw->MEMRD, sw->MEMWR.
- MEMRD->MEMWB.
- RTYPEEX->RTYPEWB.
- ADDIEX->ADDIWB.
- MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQ, BNE, JUMP->FETCH.
REQ-013 SHALL drive these outputs in FETCH: iord=0, alu_src_a=0, alu_src_b=01, aluop=00, pc_src=00, ir_write=1, pc_write=1.
REQ-014 SHALL drive in DECODE: alu_src_a=0, alu_src_b=11, aluop=00.
REQ-015 SHALL drive in MEMADR: alu_src_a=1, alu_src_b=10, aluop=00.
REQ-016 SHALL drive iord=1 in MEMRD; reg_dst=0, mem_to_reg=1, reg_write=1 in MEMWB; iord=1, mem_write=1 in MEMWR.
REQ-017 SHALL drive alu_src_a=1, alu_src_b=00, aluop=10 in RTYPEEX, and reg_dst=1, mem_to_reg=0, reg_write=1 in RTYPEWB.
REQ-018 SHALL drive alu_src_a=1, alu_src_b=10, aluop=00 in ADDIEX, and reg_dst=0, mem_to_reg=0, reg_write=1 in ADDIWB.
REQ-019 SHALL drive alu_src_a=1, alu_src_b=00, aluop=01, pc_src=01 in BEQ and BNE, with branch=1 in BEQ and branch_ne=1 in BNE.
REQ-020 SHALL drive pc_src=10, pc_write=1 in JUMP.
REQ-021 SHALL drive every output not listed for a state to 0.
REQ-022 SHALL compute pc_en = pc_write | (branch & zero) | (branch_ne & ~zero), combinationally, with zero-latency dependence on zero.
REQ-023 SHALL decode alu_control as follows:
- aluop 00 -> 010 (add); aluop 01 -> 110 (sub).
- aluop 10 by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other funct->010.
REQ-024 SHALL assert illegal_op for exactly the DECODE cycle in which the opcode is undecoded.
REQ-025 SHALL leave state and all outputs unchanged on edges where clk_en=0; each state's outputs hold for its whole enabled period.
REQ-026 SHALL make every instruction take a fixed number of enabled cycles: lw 5; sw 4; R 4; addi 4; beq/bne 3; j 3; illegal 2.

Reset
REQ-027 SHALL load state=FETCH on a rising edge with rst=1, regardless of clk_en.
REQ-028 SHALL force ir_write, pc_write, pc_en, mem_write, reg_write and illegal_op to 0 while rst=1; other outputs take their FETCH values.
REQ-029 SHALL, on rst mid-instruction (any state), abandon the instruction with no further write strobe and restart at FETCH on the first enabled edge after rst falls.

Structure
REQ-030 SHALL place the state enum, opcode constants, funct constants, aluop encodings and alu_control encodings in shared package mc_pkg.
REQ-031 SHALL split aluop/funct->alu_control decoding into combinational sub-module alu_decoder; the FSM and main decoder stay in mc_control.

Verification
REQ-032 SHALL cover lw: opcode=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, then FETCH; reg_write=1 only in MEMWB; iord=1 in MEMRD.
REQ-033 SHALL cover the R-type funct table: opcode=0 with funct 100010 -> alu_control=110 in RTYPEEX; with funct 101010 -> 111; with funct 111111 -> 010.
REQ-034 SHALL cover branches:
- beq with zero=1 -> pc_en=1 in BEQ; with zero=0 -> pc_en=0.
- bne with zero=0 -> pc_en=1.
- With BNE_EN=0, opcode 000101 -> illegal_op=1, return to FETCH.
REQ-035 SHALL cover clk_en: toggled 1/0 every clock -> each state holds 2 clocks, sw completes in 8 clocks, mem_write high for 2 clocks.
REQ-036 SHALL cover reset mid-operation: rst asserted in MEMWR -> mem_write=0 on the same cycle, state=FETCH next edge, first fetch proceeds normally.
REQ-037 SHALL cover an illegal opcode: opcode=111111 -> illegal_op single pulse in DECODE, no reg_write/mem_write/pc_en, FETCH next.
